latch_counter: RTL and testbench

LATCH_COUNTER -- requirements
Module: latch_counter

---
 rtl/latch_counter_pkg.sv | 14 +
 rtl/latch_counter_wrap_det.sv | 23 ++
 rtl/latch_counter.sv | 44 ++++
 tb/tb_latch_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/latch_counter_pkg.sv
// Shared constants for the free-running latch_counter family: default width
// and the terminal-count value for any legal width.
package latch_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MIN_WIDTH     = 2;
  localparam int unsigned MAX_WIDTH     = 16;

  // All-ones value for a counter of the given width (2^width - 1).
  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/latch_counter_wrap_det.sv
// Wrap pulse generator: flags the cycle right after the counter rolls over
// from its terminal count to zero.
module latch_counter_wrap_det
  import latch_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tc,
  output logic wrap
);

  // A rollover happens exactly when the counter sits at max and is enabled,
  // so registering that condition yields the one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= en && tc;
    end
  end

endmodule

// File: rtl/latch_counter.sv
// Enable-gated up-counter modulo 2^WIDTH with combinational terminal count
// and a registered wrap pulse. All storage is edge-triggered.
module latch_counter
  import latch_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(WIDTH));

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("latch_counter: WIDTH %0d outside 2..16", WIDTH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: the reset branch sits in the sensitivity list (negedge rst_n), so q
  // clears immediately rather than at the next clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

  assign tc = (q == MAX_Q);

  latch_counter_wrap_det u_wrap_det (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tc    (tc),
    .wrap  (wrap)
  );

endmodule

// File: tb/tb_latch_counter.sv
// Directed self-checking bench for latch_counter at WIDTH=4 and WIDTH=8
// sharing one clock and reset.
module tb_latch_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en4, en8;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       tc4, tc8, wrap4, wrap8;

  int n_tests = 0;
  int n_fail  = 0;

  latch_counter #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en4),
    .q     (q4),
    .tc    (tc4),
    .wrap  (wrap4)
  );

  latch_counter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en8),
    .q     (q8),
    .tc    (tc8),
    .wrap  (wrap8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp4;
    int exp8;

    // Reset held for two cycles with en low.
    rst_n = 1'b0;
    en4   = 1'b0;
    en8   = 1'b0;
    step();
    step();
    check("rst_q",    32'(q4),    0);
    check("rst_tc",   32'(tc4),   0);
    check("rst_wrap", 32'(wrap4), 0);
    check("rst_q8",   32'(q8),    0);

    // Release, count 1,2,3, hold 3 twice, then 4,5.
    rst_n = 1'b1;
    en4   = 1'b1;
    step(); check("cnt_1", 32'(q4), 1);
    step(); check("cnt_2", 32'(q4), 2);
    step(); check("cnt_3", 32'(q4), 3);
    en4 = 1'b0;
    step(); check("hold_3a", 32'(q4), 3);
    step(); check("hold_3b", 32'(q4), 3);
    en4 = 1'b1;
    step(); check("cnt_4", 32'(q4), 4);
    step(); check("cnt_5", 32'(q4), 5);
    check("en8_low_q8", 32'(q8), 0);

    // Asynchronous reset mid-cycle must clear before the next edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_q",    32'(q4),    0);
    check("async_tc",   32'(tc4),   0);
    check("async_wrap", 32'(wrap4), 0);
    // Edges during reset with en high must not count.
    step(); check("in_rst_q", 32'(q4), 0);
    rst_n = 1'b1;
    en4   = 1'b0;
    step(); check("post_rst_hold_a", 32'(q4), 0);
    step(); check("post_rst_hold_b", 32'(q4), 0);

    // Sixteen enabled cycles: tc only at 15, one wrap pulse on rollover.
    en4  = 1'b1;
    exp4 = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      exp4 = (exp4 + 1) % 16;
      check("run_q",    32'(q4),    32'(exp4));
      check("run_tc",   32'(tc4),   (exp4 == 15) ? 1 : 0);
      check("run_wrap", 32'(wrap4), (i == 16) ? 1 : 0);
    end

    // Climb back to 15, then hold there with en low.
    for (int i = 1; i <= 15; i++) begin
      step();
      check("climb_wrap", 32'(wrap4), 0);
    end
    check("climb_q",  32'(q4),  15);
    check("climb_tc", 32'(tc4), 1);
    en4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_max_q",    32'(q4),    15);
      check("hold_max_tc",   32'(tc4),   1);
      check("hold_max_wrap", 32'(wrap4), 0);
    end
    en4 = 1'b1;
    step();
    check("wrap2_q",    32'(q4),    0);
    check("wrap2_tc",   32'(tc4),   0);
    check("wrap2_wrap", 32'(wrap4), 1);
    en4 = 1'b0;
    step();
    check("wrap2_end_wrap", 32'(wrap4), 0);
    check("wrap2_end_q",    32'(q4),    0);

    // Alternate en every cycle from zero on both widths.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en4 = (i % 2 == 0);
      en8 = (i % 2 == 0);
      step();
    end
    en4 = 1'b0;
    en8 = 1'b0;
    check("alt_q4", 32'(q4), 5);
    check("alt_q8", 32'(q8), 5);

    // WIDTH=8: run up to 255 and across the wrap.
    en8  = 1'b1;
    exp8 = 5;
    for (int i = 0; i < 250; i++) begin
      step();
      exp8++;
      if (exp8 == 200) check("w8_mid_q", 32'(q8), 200);
    end
    check("w8_max_q",    32'(q8),    255);
    check("w8_max_tc",   32'(tc8),   1);
    check("w8_max_wrap", 32'(wrap8), 0);
    step();
    check("w8_wrap_q",    32'(q8),    0);
    check("w8_wrap_wrap", 32'(wrap8), 1);
    step();
    check("w8_after_q",    32'(q8),    1);
    check("w8_after_wrap", 32'(wrap8), 0);
    check("w8_q4_idle",    32'(q4),    5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
